cla_bus_master: RTL and testbench

- Upstream bus-master sequencer for the carry-lookahead adder slave.
- Accepts an operand pair on a valid/ready stream, then runs the slave's active-low CS/WR/RD bus protocol: write A to address 0, write B to address 1, read the sum via address 1.
- Returns the captured sum on an output valid/ready stream.
- Sits between the system-side command source and the adder register interface.

---
 rtl/cla_bus_master.sv | 156 +++++++++++++++
 tb/tb_cla_bus_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_bus_master.sv
// cla_bus_master: bus-master sequencer for the carry-lookahead adder slave.
// It accepts an operand pair, writes A to address 0 and B to address 1 over
// the slave's active-low CS/WR/RD bus, reads the sum back from address 1 and
// returns it on an output stream.
//
// Optional feature: define CLA_MASTER_TXN_COUNT_EN to add a 16-bit txn_count
// output that counts completed result handshakes and wraps at 0xFFFF.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. A source holds valid and its payload until that edge. Ready may
// be asserted without valid. This block never drops or duplicates a transfer.
module cla_bus_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  CS,
  output logic                  WR,
  output logic                  RD,
  output logic [ADD_WIDTH-1:0]  Address,
  output logic [DATA_WIDTH-1:0] Data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [2:0]            dbg_state
`ifdef CLA_MASTER_TXN_COUNT_EN
  ,
  output logic [15:0]           txn_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_A    = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  // Operand B is held here. Operand A goes straight into the registered Data
  // bus on the accept edge, so it needs no separate holding register.
  logic [DATA_WIDTH-1:0] op_b;

  logic accept;
  logic resp_done;

  // These hold the bus values for the state being entered. They are
  // registered, so the bus changes only on clock edges.
  logic                  bus_cs;
  logic                  bus_wr;
  logic                  bus_rd;
  logic [ADD_WIDTH-1:0]  bus_addr;
  logic [DATA_WIDTH-1:0] bus_data;

  assign accept    = in_valid & in_ready;
  assign resp_done = out_valid & out_ready;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: a fixed walk through the bus phases, held in RESP until the result is taken.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (accept) next_state = S_WR_A;
      S_WR_A:    next_state = S_WR_B;
      S_WR_B:    next_state = S_RD_REQ;
      S_RD_REQ:  next_state = S_RD_WAIT;
      S_RD_WAIT: next_state = S_RESP;
      S_RESP:    if (resp_done) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Output decode: bus values for the state being entered. next_state is
  // WR_A only on an accept edge, so in_a is valid when it is used here.
  always_comb begin
    bus_cs   = 1'b1;
    bus_wr   = 1'b1;
    bus_rd   = 1'b1;
    bus_addr = '0;
    bus_data = '0;
    case (next_state)
      S_WR_A: begin
        bus_cs   = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = ADD_WIDTH'(0);
        bus_data = in_a;
      end
      S_WR_B: begin
        bus_cs   = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = ADD_WIDTH'(1);
        bus_data = op_b;
      end
      S_RD_REQ: begin
        bus_cs   = 1'b0;
        bus_rd   = 1'b0;
        bus_addr = ADD_WIDTH'(1);
      end
      default: begin
        bus_cs   = 1'b1;
      end
    endcase
  end

  // Registered bus, stream flags, operand capture and sum capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      CS        <= 1'b1;
      WR        <= 1'b1;
      RD        <= 1'b1;
      Address   <= '0;
      Data      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      op_b      <= '0;
    end else begin
      CS        <= bus_cs;
      WR        <= bus_wr;
      RD        <= bus_rd;
      Address   <= bus_addr;
      Data      <= bus_data;
      in_ready  <= (next_state == S_IDLE);
      out_valid <= (next_state == S_RESP);
      if (accept) op_b <= in_b;
      // The slave registered its sum at the end of RD_REQ, so rd_data is
      // stable for the whole of RD_WAIT.
      if (state == S_RD_WAIT) out_sum <= rd_data;
    end
  end

`ifdef CLA_MASTER_TXN_COUNT_EN
  // Count completed result handshakes. The counter wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         txn_count <= 16'd0;
    else if (resp_done) txn_count <= txn_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cla_bus_master.sv
// Self-checking bench for cla_bus_master, paired with a behavioural adder slave.
// Build with +define+CLA_MASTER_TXN_COUNT_EN to also exercise txn_count.
module tb_cla_bus_master;
  localparam int DW = 32;
  localparam int AW = 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_sum;
  logic          CS, WR, RD;
  logic [AW-1:0] Address;
  logic [DW-1:0] Data;
  logic [DW-1:0] rd_data;
  logic [2:0]    dbg_state;
`ifdef CLA_MASTER_TXN_COUNT_EN
  logic [15:0]   txn_count;
`endif

  cla_bus_master #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .CS        (CS),
    .WR        (WR),
    .RD        (RD),
    .Address   (Address),
    .Data      (Data),
    .rd_data   (rd_data),
    .dbg_state (dbg_state)
`ifdef CLA_MASTER_TXN_COUNT_EN
    ,
    .txn_count (txn_count)
`endif
  );

  // ---------------- adder slave model ----------------
  logic [DW-1:0] s_a   = '0;
  logic [DW-1:0] s_b   = '0;
  logic [DW-1:0] s_res = '0;
  always @(posedge clock) begin
    if (!CS && !WR) begin
      if (Address == AW'(0)) s_a <= Data;
      else                   s_b <= Data;
    end
    if (!CS && !RD) s_res <= s_a + s_b;
  end
  assign rd_data = s_res;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Advance one edge and sample 1 time unit later.
  // Every cycle also checks that the bus never strobes illegally.
  task automatic tick();
    @(posedge clock);
    #1;
    n_tests++;
    if ((!WR && !RD) || (CS && (!WR || !RD))) begin
      n_fail++;
      $display("FAIL bus_strobe: CS=%0b WR=%0b RD=%0b, need no WR+RD overlap and no strobe without CS", CS, WR, RD);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a pair, hold it until in_ready, let the accept edge pass, and queue the expected sum.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    logic [DW-1:0] e;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, need 1", in_ready, n);
      in_valid = 1'b0;
    end else begin
      tick();
      e = a + b;
      exp_q.push_back(e);
      in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for out_valid and compare out_sum against the scoreboard.
  task automatic wait_resp();
    int n;
    logic [DW-1:0] e;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL resp_timeout: out_valid=%0b, need 1", out_valid);
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL resp_unexpected: out_sum=%h with empty scoreboard", out_sum);
    end else begin
      e = exp_q.pop_front();
      if (out_sum !== e) begin
        n_fail++;
        $display("FAIL resp_sum: out_sum=%h, need %h", out_sum, e);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || CS !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold: in_ready=%0b CS=%0b, need 0 1", in_ready, CS);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    n_tests++;
    if ({CS, WR, RD} !== 3'b111 || out_valid !== 1'b0 || out_sum !== '0 ||
        Address !== AW'(0) || Data !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: CS%0b WR%0b RD%0b ov%0b sum=%h addr=%0h data=%h rdy%0b, need 111 0 0 0 0 1",
               CS, WR, RD, out_valid, out_sum, Address, Data, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [2:0]    exp_ctl  [4];
    logic [AW-1:0] exp_addr [4];
    logic [DW-1:0] exp_data [4];
    logic [DW-1:0] e;
    exp_ctl[0] = 3'b001; exp_addr[0] = AW'(0); exp_data[0] = 32'd5;
    exp_ctl[1] = 3'b001; exp_addr[1] = AW'(1); exp_data[1] = 32'd7;
    exp_ctl[2] = 3'b010; exp_addr[2] = AW'(1); exp_data[2] = 32'd0;
    exp_ctl[3] = 3'b111; exp_addr[3] = AW'(0); exp_data[3] = 32'd0;
    out_ready = 1'b1;
    send(32'd5, 32'd7);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({CS, WR, RD} !== exp_ctl[i] || Address !== exp_addr[i] || Data !== exp_data[i] ||
          in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_bus%0d: ctl=%b addr=%0h data=%h rdy=%0b ov=%0b, need ctl=%b addr=%0h data=%h rdy=0 ov=0",
                 i, {CS, WR, RD}, Address, Data, in_ready, out_valid, exp_ctl[i], exp_addr[i], exp_data[i]);
      end
      tick();
    end
    // This is the fifth cycle after the accept edge, so the result must be presented now.
    n_tests++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid=%0b, need 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      n_tests++;
      if (out_sum !== e) begin
        n_fail++;
        $display("FAIL basic_sum: out_sum=%h, need %h", out_sum, e);
      end
    end
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: in_ready=%0b out_valid=%0b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001);
    wait_resp();
    tick();
    send(32'h8000_0000, 32'h8000_0000);
    wait_resp();
    tick();
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] held;
    out_ready = 1'b0;
    send(32'd10, 32'd20);
    wait_resp();
    held = 32'd30;
    in_valid = 1'b1;
    in_a     = 32'd100;
    in_b     = 32'd200;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_sum !== held || in_ready !== 1'b0 || {CS, WR, RD} !== 3'b111) begin
        n_fail++;
        $display("FAIL bp_hold%0d: ov=%0b sum=%h rdy=%0b ctl=%b, need 1 %h 0 111",
                 i, out_valid, out_sum, in_ready, {CS, WR, RD}, held);
      end
    end
    out_ready = 1'b1;
    send(32'd100, 32'd200);
    wait_resp();
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(32'd9, 32'd9);
    tick();
    // The DUT is now in WR_B, so the reset lands in the middle of the write phase.
    n_tests++;
    if (CS !== 1'b0 || WR !== 1'b0 || Address !== AW'(1)) begin
      n_fail++;
      $display("FAIL mid_pre: CS=%0b WR=%0b addr=%0h, need 0 0 1", CS, WR, Address);
    end
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if ({CS, WR, RD} !== 3'b111 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
        Address !== AW'(0) || Data !== '0) begin
      n_fail++;
      $display("FAIL mid_async: ctl=%b ov=%0b rdy=%0b addr=%0h data=%h, need 111 0 0 0 0",
               {CS, WR, RD}, out_valid, in_ready, Address, Data);
    end
    exp_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_abandon%0d: out_valid=%0b, need 0", i, out_valid);
      end
    end
    send(32'd3, 32'd4);
    wait_resp();
    tick();
  endtask

`ifdef CLA_MASTER_TXN_COUNT_EN
  task automatic test_txn_count();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send($urandom, $urandom);
      wait_resp();
      tick();
    end
    n_tests++;
    if (txn_count !== 16'd3) begin
      n_fail++;
      $display("FAIL txn_three: txn_count=%0d, need 3", txn_count);
    end
    @(negedge clock);
    force dut.txn_count = 16'hFFFF;
    #1 release dut.txn_count;
    send(32'd1, 32'd2);
    wait_resp();
    tick();
    n_tests++;
    if (txn_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL txn_wrap: txn_count=%h, need 0000", txn_count);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1;
      send($urandom, $urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      wait_resp();
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_pressure();
    test_reset_mid();
    test_random();
`ifdef CLA_MASTER_TXN_COUNT_EN
    test_txn_count();
`endif
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d results still expected, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
